raifes_uart_rx: RTL and testbench

- UART receiver, 8N1, LSB first, idle-high line; the receive-side counterpart of the team's UART transmitter.
- Synchronises the asynchronous RX pin, validates the start bit at mid-bit, samples 8 data bits and the stop bit at bit centres, then presents the byte on a valid/ack handshake.
- Sits between the board RX pin and the core's peripheral/debug logic. Default timing is 9600 baud at 50 MHz.

---
 rtl/raifes_uart_defs.sv | 28 ++
 rtl/raifes_sync2.sv | 27 ++
 rtl/raifes_uart_rx.sv | 156 +++++++++++++++
 tb/tb_raifes_uart_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/raifes_uart_defs.sv
// raifes_uart_defs
//   Shared UART definitions for the receiver and the transmitter:
//   default bit timing (9600 baud at 50 MHz), frame geometry and the
//   receiver state encodings.
package raifes_uart_defs;

    // Bit period in clocks minus 1: round(50e6 / 9600) - 1 = 5207.
    localparam logic [15:0] UART_CNT_MAX  = 16'h1457;

    // Half-bit delay in clocks minus 1, used to centre on the start bit.
    function automatic logic [15:0] uart_half_of(input logic [15:0] cnt_max);
        return cnt_max >> 1;
    endfunction

    localparam logic [15:0] UART_HALF_MAX = uart_half_of(UART_CNT_MAX);

    // 8N1 frame: one start bit, 8 data bits LSB first, one stop bit.
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/raifes_sync2.sv
// raifes_sync2
//   Two-flop synchroniser for a single asynchronous input.
//   Ports: clk, reset (sync, active-high), d (async in), q (synchronised out).
//   Both flops load RESET_VAL in reset so an idle-high line reads idle.
module raifes_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            // second stage: metastability settles here
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/raifes_uart_rx.sv
// raifes_uart_rx
//   8N1 UART receiver, LSB first, idle-high line. Checks the start bit at
//   mid-bit, samples data and stop at bit centres and presents the byte on
//   a valid/ack handshake.
//   Ports:
//     clk, reset      system clock, synchronous active-high reset
//     UART_RX         asynchronous serial line (idle 1)
//     rdata           received byte, meaningful while valid = 1
//     valid           byte available, held until ack
//     ack             one-cycle strobe; clears valid, overrun, frame_err
//     frame_err       sticky: stop bit sampled as 0
//     overrun         sticky: new byte completed while valid still set
//     busy            receiver is not idle
module raifes_uart_rx
    import raifes_uart_defs::*;
#(
    parameter logic [15:0] CNT_MAX  = UART_CNT_MAX,
    parameter logic [15:0] HALF_MAX = uart_half_of(CNT_MAX)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      UART_RX,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      valid,
    input  logic                      ack,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    logic                      rx_s;
    rx_state_t                 state, state_n;
    logic [15:0]               timer, timer_n;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      tick;
    logic                      bit_clr;
    logic                      sample;
    logic                      deliver;
    logic                      ferr_set;

    raifes_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (UART_RX),
        .q     (rx_s)
    );

    assign tick = (timer == 16'd0);
    assign busy = (state != RX_IDLE);

    always_comb begin
        state_n  = state;
        // Timer parks at zero whenever no reload is requested.
        timer_n  = tick ? 16'd0 : timer - 16'd1;
        bit_clr  = 1'b0;
        sample   = 1'b0;
        deliver  = 1'b0;
        ferr_set = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s) begin
                    timer_n = HALF_MAX;
                    state_n = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        timer_n = CNT_MAX;
                        bit_clr = 1'b1;
                        state_n = RX_DATA;
                    end else begin
                        // Line went high again before mid-bit: glitch.
                        state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    sample  = 1'b1;
                    timer_n = CNT_MAX;
                    if (bit_idx == 3'd7) begin
                        state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                // Hold off until the line releases so a held-low line
                // cannot look like a stream of start bits.
                if (rx_s) begin
                    state_n = RX_IDLE;
                end
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_IDLE;
            timer     <= 16'd0;
            bit_idx   <= 3'd0;
            rdata     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (sample) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // A delivery in the same cycle as ack wins over the clear.
            if (deliver) begin
                rdata <= shreg;
                valid <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end
            if (deliver && valid && !ack) begin
                overrun <= 1'b1;
            end else if (ack) begin
                overrun <= 1'b0;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end else if (ack) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Data shift register: LSB arrives first, so shift in from the top.
    always_ff @(posedge clk) begin
        if (sample) begin
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        end
    end

endmodule

// File: tb/tb_raifes_uart_rx.sv
module tb_raifes_uart_rx;

    localparam logic [15:0] CNT  = 16'd15;
    localparam logic [15:0] HALF = 16'd7;
    localparam int BIT_CLKS = int'(CNT) + 1;
    // Edges from the first edge that sees the pin low (counted as N) to the
    // edge that raises valid: sync (2) + half bit + start/8 data/stop centres.
    localparam int LAT = 2 + (int'(HALF) + 1) + 9 * (int'(CNT) + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] rdata;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    raifes_uart_rx #(.CNT_MAX(CNT), .HALF_MAX(HALF)) dut (
        .clk       (clk),
        .reset     (reset),
        .UART_RX   (uart_rx),
        .rdata     (rdata),
        .valid     (valid),
        .ack       (ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       exp_valid = 1'b0;
    logic       exp_ferr = 1'b0;
    logic       exp_ovr = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20) begin
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
            end
        end
    endtask

    // Behavioural model: each frame sent produces one outcome at a fixed
    // edge; ack and reset act on the handshake flags at the edge they are seen.
    initial begin
        forever begin
            logic was_valid;
            @(posedge clk);
            cyc++;
            if (reset) begin
                exp_valid = 1'b0;
                exp_ferr  = 1'b0;
                exp_ovr   = 1'b0;
                exp_rdata = 8'h00;
                evq.delete();
            end else begin
                was_valid = exp_valid;
                if (ack) begin
                    exp_valid = 1'b0;
                    exp_ovr   = 1'b0;
                    exp_ferr  = 1'b0;
                end
                while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                    ev_t e;
                    e = evq.pop_front();
                    if (e.ferr) begin
                        exp_ferr = 1'b1;
                    end else begin
                        if (was_valid && !ack) exp_ovr = 1'b1;
                        exp_valid = 1'b1;
                        exp_rdata = e.b;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                check("cyc_valid", 32'(valid), 32'(exp_valid));
                check("cyc_frame_err", 32'(frame_err), 32'(exp_ferr));
                check("cyc_overrun", 32'(overrun), 32'(exp_ovr));
                if (exp_valid) begin
                    check("cyc_rdata", 32'(rdata), 32'(exp_rdata));
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        ev_t        e;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        e.cyc  = cyc + 1 + LAT;
        e.ferr = !stop;
        e.b    = b;
        evq.push_back(e);
        for (int i = 0; i < 10; i++) begin
            uart_rx = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] part;
        int         tgt;
        bit         busy_seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Single good frame 0xA5
        send_frame(8'hA5, 1'b1);
        check("a5_valid", 32'(valid), 32'h1);
        check("a5_rdata", 32'(rdata), 32'hA5);
        check("a5_frame_err", 32'(frame_err), 32'h0);
        check("a5_busy", 32'(busy), 32'h0);
        ack_pulse();
        check("a5_ack_valid", 32'(valid), 32'h0);

        // Back-to-back without ack -> overrun, newest byte kept
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check("ovr_rdata", 32'(rdata), 32'hFF);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_overrun", 32'(overrun), 32'h1);
        ack_pulse();
        check("ovr_ack_overrun", 32'(overrun), 32'h0);
        check("ovr_ack_valid", 32'(valid), 32'h0);

        // 4-clock low glitch on idle line
        @(negedge clk);
        uart_rx = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        uart_rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        check("glitch_busy_pulse", 32'(busy_seen), 32'h1);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_frame_err", 32'(frame_err), 32'h0);

        // Bad stop bit, line held low, then released
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        check("brk_busy_low", 32'(busy), 32'h1);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        check("brk_frame_err", 32'(frame_err), 32'h1);
        check("brk_valid", 32'(valid), 32'h0);
        check("brk_busy", 32'(busy), 32'h0);
        send_frame(8'h3C, 1'b1);
        check("brk_next_valid", 32'(valid), 32'h1);
        check("brk_next_rdata", 32'(rdata), 32'h3C);
        ack_pulse();
        check("brk_ack_frame_err", 32'(frame_err), 32'h0);

        // Reset during data bit 4 of 0x81
        part = 8'h81;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = part[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        uart_rx = part[4];
        repeat (8) @(negedge clk);
        check("rstmid_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_rdata", 32'(rdata), 32'h00);
        repeat (30) @(negedge clk);
        check("rstmid_valid", 32'(valid), 32'h0);
        send_frame(8'h81, 1'b1);
        check("rstmid_next_valid", 32'(valid), 32'h1);
        check("rstmid_next_rdata", 32'(rdata), 32'h81);

        // ack on the same edge as delivery of 0x5A while valid is set
        fork
            send_frame(8'h5A, 1'b1);
            begin
                @(negedge clk);
                tgt = cyc + 1 + LAT;
                while (cyc < tgt - 1) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
        join
        check("coin_valid", 32'(valid), 32'h1);
        check("coin_rdata", 32'(rdata), 32'h5A);
        check("coin_overrun", 32'(overrun), 32'h0);
        ack_pulse();
        check("coin_ack_valid", 32'(valid), 32'h0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
